// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the adder result checker.
package adder_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 2;
  localparam int DEF_TAG_W = 8;
  localparam int DEF_CNT_W = 16;

  // Bit positions inside a half_adder result word.
  localparam int SUM_BIT  = 0;
  localparam int COUT_BIT = 1;

endpackage

// File: rtl/add_result_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/add_result_checker.sv
// Streaming checker comparing adder results against golden words; counts
// matches/mismatches and captures the first failing vector of each run.
module add_result_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int TAG_W        = DEF_TAG_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int NUM_VEC      = 4,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] actual,
  input  logic [WIDTH-1:0] expected,
  input  logic [TAG_W-1:0] tag,
  output logic             busy,
  output logic             done,
  output logic             err_flag,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [TAG_W-1:0] ff_tag,
  output logic [WIDTH-1:0] ff_actual,
  output logic [WIDTH-1:0] ff_expected,
  output state_t           state
);

  // Accepted-vector counter is sized from NUM_VEC, independent of CNT_W,
  // so small saturating counters still allow long runs.
  localparam int ACC_W = $clog2(NUM_VEC + 1);

  state_t           state_q, state_d;
  logic             accept, mism, clr, last;
  logic [ACC_W-1:0] acc_cnt;

  // Handshake: a vector transfers on a rising edge where in_valid && in_ready.
  // in_ready is a pure function of the state register (high only in RUN), so
  // the source may hold or drop in_valid freely; bubbles cost nothing.
  assign in_ready = (state_q == RUN);
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign state    = state_q;

  assign accept = in_valid && in_ready;
  assign mism   = (actual !== expected);
  assign clr    = start && (state_q != RUN);
  assign last   = (acc_cnt == ACC_W'(NUM_VEC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && (last || (STOP_ON_FAIL && mism))) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt     <= '0;
      err_flag    <= 1'b0;
      ff_tag      <= '0;
      ff_actual   <= '0;
      ff_expected <= '0;
    end else if (clr) begin
      acc_cnt     <= '0;
      err_flag    <= 1'b0;
      ff_tag      <= '0;
      ff_actual   <= '0;
      ff_expected <= '0;
    end else if (accept) begin
      acc_cnt <= acc_cnt + ACC_W'(1);
      if (mism) begin
        err_flag <= 1'b1;
        if (!err_flag) begin
          ff_tag      <= tag;
          ff_actual   <= actual;
          ff_expected <= expected;
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_match (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (accept && !mism),
    .q   (match_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mismatch (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (accept && mism),
    .q   (mismatch_cnt)
  );

endmodule

// File: tb/tb_add_result_checker.sv
// Bench for add_result_checker: three configurations (default, stop-on-fail,
// narrow saturating counters) driven against a reference model and scoreboard.
module tb_add_result_checker;
  import adder_chk_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v [3];
  logic       valid_v [3];
  logic [1:0] act, exp_w;
  logic [7:0] tag;

  logic        rdy0, busy0, done0, err0, rdy1, busy1, done1, err1, rdy2, busy2, done2, err2;
  logic [15:0] mc0, mm0, mc1, mm1;
  logic [1:0]  mc2, mm2;
  logic [7:0]  fft0, fft1, fft2;
  logic [1:0]  ffa0, ffa1, ffa2, ffe0, ffe1, ffe2;
  state_t      st0, st1, st2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [35:0] exp_q [$];

  // Reference model, one entry per DUT; m_st: 0 idle, 1 run, 2 done.
  int         m_st [3], m_match [3], m_mis [3], m_acc [3];
  logic       m_err [3];
  logic [7:0] m_fft [3];
  logic [1:0] m_ffa [3], m_ffe [3];
  int         cfg_max [3] = '{65535, 65535, 3};
  int         cfg_nvec [3] = '{4, 4, 6};
  bit         cfg_stop [3] = '{1'b0, 1'b1, 1'b0};

  logic [1:0] ha_exp [4] = '{2'b00, 2'b01, 2'b01, 2'b10};

  always #5 clk = ~clk;

  add_result_checker dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(valid_v[0]), .in_ready(rdy0),
    .actual(act), .expected(exp_w), .tag(tag), .busy(busy0), .done(done0),
    .err_flag(err0), .match_cnt(mc0), .mismatch_cnt(mm0), .ff_tag(fft0),
    .ff_actual(ffa0), .ff_expected(ffe0), .state(st0)
  );

  add_result_checker #(.STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(valid_v[1]), .in_ready(rdy1),
    .actual(act), .expected(exp_w), .tag(tag), .busy(busy1), .done(done1),
    .err_flag(err1), .match_cnt(mc1), .mismatch_cnt(mm1), .ff_tag(fft1),
    .ff_actual(ffa1), .ff_expected(ffe1), .state(st1)
  );

  add_result_checker #(.CNT_W(2), .NUM_VEC(6)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(valid_v[2]), .in_ready(rdy2),
    .actual(act), .expected(exp_w), .tag(tag), .busy(busy2), .done(done2),
    .err_flag(err2), .match_cnt(mc2), .mismatch_cnt(mm2), .ff_tag(fft2),
    .ff_actual(ffa2), .ff_expected(ffe2), .state(st2)
  );

  function automatic logic [35:0] obs(input int d);
    case (d)
      0:       return {rdy0, busy0, done0, err0, mc0, mm0};
      1:       return {rdy1, busy1, done1, err1, mc1, mm1};
      default: return {rdy2, busy2, done2, err2, 14'd0, mc2, 14'd0, mm2};
    endcase
  endfunction

  function automatic logic [11:0] obs_ff(input int d);
    case (d)
      0:       return {fft0, ffa0, ffe0};
      1:       return {fft1, ffa1, ffe1};
      default: return {fft2, ffa2, ffe2};
    endcase
  endfunction

  function automatic logic [35:0] model_obs(input int d);
    logic r;
    r = (m_st[d] == 1);
    return {r, r, (m_st[d] == 2), m_err[d], 16'(m_match[d]), 16'(m_mis[d])};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic model_clear(input int d);
    m_match[d] = 0; m_mis[d] = 0; m_acc[d] = 0; m_err[d] = 1'b0;
    m_fft[d] = '0; m_ffa[d] = '0; m_ffe[d] = '0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      model_clear(d);
      m_st[d] = 0;
    end
  endtask

  task automatic do_start(input int d);
    start_v[d] = 1'b1;
    @(posedge clk);
    #1 start_v[d] = 1'b0;
    if (m_st[d] != 1) begin
      model_clear(d);
      m_st[d] = 1;
    end
    exp_q.push_back(model_obs(d));
    check($sformatf("start%0d", d), obs(d), exp_q.pop_front());
  endtask

  // Present one vector for a single cycle, then idle for gap cycles.
  task automatic send(input int d, input logic [7:0] t, input logic [1:0] a,
                      input logic [1:0] e, input int gap);
    logic mis;
    tag = t; act = a; exp_w = e; valid_v[d] = 1'b1;
    if (m_st[d] == 1) begin
      mis = (a != e);
      if (mis) begin
        if (!m_err[d]) begin
          m_fft[d] = t; m_ffa[d] = a; m_ffe[d] = e;
        end
        m_err[d] = 1'b1;
        if (m_mis[d] < cfg_max[d]) m_mis[d]++;
      end else if (m_match[d] < cfg_max[d]) begin
        m_match[d]++;
      end
      m_acc[d]++;
      if (m_acc[d] == cfg_nvec[d] || (cfg_stop[d] && mis)) m_st[d] = 2;
    end
    exp_q.push_back(model_obs(d));
    @(posedge clk);
    #1 valid_v[d] = 1'b0;
    check($sformatf("vec%0d_t%0d", d, t), obs(d), exp_q.pop_front());
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic check_ff(input int d);
    check($sformatf("ff%0d", d), obs_ff(d), {m_fft[d], m_ffa[d], m_ffe[d]});
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 1'b0;
      valid_v[d] = 1'b0;
    end
    act = '0; exp_w = '0; tag = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset%0d", d), obs(d), model_obs(d));
      check_ff(d);
    end

    // Clean half-adder run.
    do_start(0);
    for (int i = 0; i < 4; i++) send(0, 8'(i), ha_exp[i], ha_exp[i], 0);
    check_ff(0);
    // Vectors after done are ignored.
    send(0, 8'd9, 2'b11, 2'b00, 0);

    // Two mismatches; only the first is captured.
    do_start(0);
    send(0, 8'd0, 2'b00, ha_exp[0], 0);
    send(0, 8'd1, 2'b01, ha_exp[1], 0);
    send(0, 8'd2, 2'b00, ha_exp[2], 0);
    send(0, 8'd3, 2'b11, ha_exp[3], 0);
    check_ff(0);

    // Stop-on-fail configuration.
    do_start(1);
    send(1, 8'd0, 2'b00, ha_exp[0], 0);
    send(1, 8'd1, 2'b10, ha_exp[1], 0);
    send(1, 8'd2, 2'b01, ha_exp[2], 0);
    send(1, 8'd3, 2'b00, ha_exp[3], 0);
    check_ff(1);

    // Asynchronous reset mid-run: outputs clear before any clock edge.
    do_start(0);
    send(0, 8'd0, ha_exp[0], ha_exp[0], 0);
    send(0, 8'd1, ha_exp[1], ha_exp[1], 0);
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst", obs(0), model_obs(0));
    check_ff(0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Vector in IDLE is ignored; gapped run with a start in RUN ignored.
    send(0, 8'd7, 2'b11, 2'b00, 1);
    do_start(0);
    send(0, 8'd0, ha_exp[0], ha_exp[0], 3);
    send(0, 8'd1, ha_exp[1], ha_exp[1], 3);
    do_start(0);
    send(0, 8'd2, ha_exp[2], ha_exp[2], 3);
    send(0, 8'd3, ha_exp[3], ha_exp[3], 3);
    check("idle_hold", obs(0), model_obs(0));

    // Narrow counters saturate; run length follows NUM_VEC.
    do_start(2);
    for (int i = 0; i < 6; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(0, 3));
      send(2, 8'(i), v, v, $urandom_range(0, 1));
    end
    do_start(2);
    send(2, 8'd0, 2'b01, 2'b10, 0);
    check_ff(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
